// File: rtl/modclk_decoder_pkg.sv
// Shared types and SYM_LEN-derived constants for the 25%/75% modulated-clock decoder.
package modclk_decoder_pkg;

    localparam int DEF_SYM_LEN = 4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Cycles without a rise before a timeout event fires.
    function automatic int timeout_cycles(input int sym_len);
        return 2 * sym_len;
    endfunction

    // Width of the period / high-time counters; they never exceed the timeout value.
    function automatic int meas_width(input int sym_len);
        return $clog2(timeout_cycles(sym_len) + 1);
    endfunction

endpackage

// File: rtl/modclk_sync_edge.sv
// Two-flop synchronizer for the link line, plus a delayed copy for rising-edge detection.
module modclk_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_s,
    output logic o_rise
);

    logic r_meta;
    logic r_s;
    logic r_s_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_s    <= 1'b0;
            r_s_d  <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_s    <= r_meta;
            r_s_d  <= r_s;
        end
    end

    assign o_s    = r_s;
    assign o_rise = r_s & ~r_s_d;

endmodule

// File: rtl/modclk_decoder.sv
// Receive-side decoder: measures period and high time between rises of the
// synchronized line, qualifies symbols, and tracks lock with a HUNT/VERIFY/LOCKED FSM.
module modclk_decoder
    import modclk_decoder_pkg::*;
#(
    parameter int SYM_LEN    = DEF_SYM_LEN,
    parameter int LOCK_GOOD  = 16,
    parameter int UNLOCK_BAD = 4,
    parameter int ERR_W      = 16
) (
    input  logic             osc_clk0,
    input  logic             reset_n,
    input  logic             mod_in,
    input  logic             enable,
    input  logic             clr_err,
    output logic             sym_valid,
    output logic             sym_bit,
    output logic             trig_level,
    output logic             trig_rise,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int MEAS_W = meas_width(SYM_LEN);
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);
    localparam logic [MEAS_W-1:0] C_SYM     = MEAS_W'(SYM_LEN);
    localparam logic [MEAS_W-1:0] C_HI_ONE  = MEAS_W'(1);
    localparam logic [MEAS_W-1:0] C_HI_BIT1 = MEAS_W'(SYM_LEN - 1);
    localparam logic [MEAS_W-1:0] C_TMO     = MEAS_W'(timeout_cycles(SYM_LEN));

    logic w_s;
    logic w_rise;

    modclk_sync_edge u_sync (
        .i_clk   (osc_clk0),
        .i_rst_n (reset_n),
        .i_async (mod_in),
        .o_s     (w_s),
        .o_rise  (w_rise)
    );

    logic [MEAS_W-1:0] r_per;
    logic [MEAS_W-1:0] r_hi;
    logic              w_timeout;
    logic              w_good;
    logic              w_bit;
    logic              w_bad_evt;

    assign w_timeout = ~w_rise && (r_per == C_TMO);
    assign w_good    = (r_per == C_SYM) && ((r_hi == C_HI_ONE) || (r_hi == C_HI_BIT1));
    assign w_bit     = (r_hi == C_HI_BIT1);
    assign w_bad_evt = (w_rise && ~w_good) || w_timeout;

    // A rise or a timeout restarts measurement; the current sample seeds the high count.
    always_ff @(posedge osc_clk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_per <= '0;
            r_hi  <= '0;
        end else if (w_rise || w_timeout) begin
            r_per <= C_HI_ONE;
            r_hi  <= MEAS_W'(w_s);
        end else begin
            if (r_per != C_TMO) begin
                r_per <= r_per + 1'b1;
            end
            r_hi <= r_hi + MEAS_W'(w_s);
        end
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [GOOD_W-1:0] w_good_cnt_next;
    logic [BAD_W-1:0]  r_bad_cnt;
    logic [BAD_W-1:0]  w_bad_cnt_next;
    logic              r_sym_valid;
    logic              r_sym_bit;
    logic              r_trig_level;
    logic              r_trig_rise;
    logic [ERR_W-1:0]  r_err_count;
    logic              w_valid_next;
    logic              w_bit_next;
    logic              w_level_next;
    logic              w_trig_rise_next;
    logic              w_err_inc;

    always_comb begin
        w_state_next     = r_state;
        w_good_cnt_next  = r_good_cnt;
        w_bad_cnt_next   = r_bad_cnt;
        w_valid_next     = 1'b0;
        w_bit_next       = 1'b0;
        w_level_next     = r_trig_level;
        w_trig_rise_next = 1'b0;
        w_err_inc        = 1'b0;
        case (r_state)
            ST_HUNT: begin
                // The first rise only arms the measurement counters.
                w_good_cnt_next = '0;
                w_bad_cnt_next  = '0;
                if (w_rise) begin
                    w_state_next = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (w_rise && w_good) begin
                    if (r_good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
                        w_state_next   = ST_LOCKED;
                        w_bad_cnt_next = '0;
                    end else begin
                        w_good_cnt_next = r_good_cnt + 1'b1;
                    end
                end else if (w_bad_evt) begin
                    w_state_next = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (w_rise && w_good) begin
                    w_valid_next     = 1'b1;
                    w_bit_next       = w_bit;
                    w_level_next     = w_bit;
                    w_trig_rise_next = w_bit & ~r_trig_level;
                    w_bad_cnt_next   = '0;
                end else if (w_bad_evt) begin
                    w_err_inc = 1'b1;
                    if (r_bad_cnt == BAD_W'(UNLOCK_BAD - 1)) begin
                        w_state_next = ST_HUNT;
                        w_level_next = 1'b0;
                    end else begin
                        w_bad_cnt_next = r_bad_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_HUNT;
                w_level_next = 1'b0;
            end
        endcase
        if (!enable) begin
            w_state_next     = ST_HUNT;
            w_valid_next     = 1'b0;
            w_bit_next       = 1'b0;
            w_level_next     = 1'b0;
            w_trig_rise_next = 1'b0;
            w_err_inc        = 1'b0;
        end
    end

    always_ff @(posedge osc_clk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_HUNT;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
            r_sym_valid  <= 1'b0;
            r_sym_bit    <= 1'b0;
            r_trig_level <= 1'b0;
            r_trig_rise  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_good_cnt   <= w_good_cnt_next;
            r_bad_cnt    <= w_bad_cnt_next;
            r_sym_valid  <= w_valid_next;
            r_sym_bit    <= w_bit_next;
            r_trig_level <= w_level_next;
            r_trig_rise  <= w_trig_rise_next;
        end
    end

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge osc_clk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (clr_err) begin
            r_err_count <= '0;
        end else if (w_err_inc && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign sym_valid  = r_sym_valid;
    assign sym_bit    = r_sym_bit;
    assign trig_level = r_trig_level;
    assign trig_rise  = r_trig_rise;
    assign locked     = (r_state == ST_LOCKED);
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_modclk_decoder.sv
// Self-checking bench for modclk_decoder: directed scenarios plus random symbol
// streams, checked every cycle against a cycle-count model of the decoding rules.
module tb_modclk_decoder;

    localparam int SYM  = 4;
    localparam int LOCK = 16;
    localparam int UNLK = 4;
    localparam int TMO  = 2 * SYM;
    localparam int EMAX = 65535;

    logic        osc_clk0 = 1'b0;
    logic        reset_n;
    logic        mod_in;
    logic        enable;
    logic        clr_err;
    logic        sym_valid;
    logic        sym_bit;
    logic        trig_level;
    logic        trig_rise;
    logic        locked;
    logic [15:0] err_count;

    modclk_decoder dut (
        .osc_clk0   (osc_clk0),
        .reset_n    (reset_n),
        .mod_in     (mod_in),
        .enable     (enable),
        .clr_err    (clr_err),
        .sym_valid  (sym_valid),
        .sym_bit    (sym_bit),
        .trig_level (trig_level),
        .trig_rise  (trig_rise),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #8 osc_clk0 = ~osc_clk0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: line samples pass two flops, then symbols are judged from
    // cycle counts since the last rise (or timeout) and the number of high samples.
    bit m_meta, m_s, m_sd;
    int m_per, m_hi, m_st, m_good, m_bad, m_err;
    bit e_valid, e_bit, e_level, e_rise;

    task automatic model_reset();
        m_meta = 0; m_s = 0; m_sd = 0;
        m_per = 0; m_hi = 0; m_st = 0; m_good = 0; m_bad = 0; m_err = 0;
        e_valid = 0; e_bit = 0; e_level = 0; e_rise = 0;
    endtask

    task automatic model_step();
        bit rise, tmo, good, bv, inc;
        int nst;
        rise = m_s && !m_sd;
        tmo  = !rise && (m_per == TMO);
        good = (m_per == SYM) && (m_hi == 1 || m_hi == SYM - 1);
        bv   = (m_hi == SYM - 1);
        e_valid = 0; e_bit = 0; e_rise = 0; inc = 0;
        nst = m_st;
        if (!enable) begin
            nst = 0;
            e_level = 0;
        end else if (m_st == 0) begin
            if (rise) begin
                nst = 1;
                m_good = 0;
            end
        end else if (m_st == 1) begin
            if (rise && good) begin
                m_good++;
                if (m_good == LOCK) begin
                    nst = 2;
                    m_bad = 0;
                end
            end else if (rise || tmo) begin
                nst = 0;
            end
        end else begin
            if (rise && good) begin
                e_valid = 1;
                e_bit   = bv;
                e_rise  = bv && !e_level;
                e_level = bv;
                m_bad   = 0;
            end else if (rise || tmo) begin
                inc = 1;
                m_bad++;
                if (m_bad == UNLK) begin
                    nst = 0;
                    e_level = 0;
                end
            end
        end
        if (clr_err) m_err = 0;
        else if (inc && m_err != EMAX) m_err++;
        m_st = nst;
        if (rise || tmo) begin
            m_per = 1;
            m_hi  = m_s;
        end else begin
            if (m_per < TMO) m_per++;
            m_hi += m_s;
        end
        m_sd = m_s; m_s = m_meta; m_meta = mod_in;
    endtask

    function automatic logic [4:0] dut_outs();
        return {locked, sym_valid, sym_bit & sym_valid, trig_level, trig_rise};
    endfunction

    int cnt_valid, cnt_one, cnt_trig;

    task automatic tick();
        @(posedge osc_clk0);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        check_eq("outs", {27'd0, dut_outs()},
                 {27'd0, (m_st == 2), e_valid, e_bit & e_valid, e_level, e_rise});
        check_eq("err_count", {16'd0, err_count}, m_err);
        if (sym_valid) cnt_valid++;
        if (sym_valid && sym_bit) cnt_one++;
        if (trig_rise) cnt_trig++;
    endtask

    task automatic send_sym(input int hi, input int len);
        for (int i = 0; i < len; i++) begin
            mod_in = (i < hi);
            tick();
        end
    endtask

    task automatic send_n(input int hi, input int n);
        for (int i = 0; i < n; i++) send_sym(hi, SYM);
    endtask

    task automatic clr_counts();
        cnt_valid = 0; cnt_one = 0; cnt_trig = 0;
    endtask

    initial begin
        reset_n = 0; mod_in = 0; enable = 1; clr_err = 0;
        model_reset();
        clr_counts();
        repeat (3) tick();
        check_eq("reset_vals", {27'd0, dut_outs()}, 0);
        check_eq("reset_err", {16'd0, err_count}, 0);
        reset_n = 1;
        repeat (3) tick();

        // 20 symbols of 25%: lock on rise 17, then three bit-0 strobes
        clr_counts();
        send_n(1, 20);
        check_eq("lock_first", locked, 1);
        check_eq("valid_after_lock", cnt_valid, 3);
        check_eq("ones_25pct", cnt_one, 0);
        $display("[TB] lock phase: locked=%0d valids=%0d err=%0d", locked, cnt_valid, err_count);

        // three 75% symbols, then 25%
        clr_counts();
        send_n(3, 3);
        send_n(1, 3);
        check_eq("ones_75pct", cnt_one, 3);
        check_eq("trig_rise_cnt", cnt_trig, 1);
        check_eq("trig_level_end", trig_level, 0);
        check_eq("valid_75pct", cnt_valid, 6);
        $display("[TB] trigger phase: ones=%0d rises=%0d", cnt_one, cnt_trig);

        // one 2-cycle-high symbol
        clr_counts();
        send_sym(2, SYM);
        send_n(1, 4);
        check_eq("err_glitch", err_count, 1);
        check_eq("lock_glitch", locked, 1);
        check_eq("valid_glitch", cnt_valid, 4);
        $display("[TB] glitch phase: err=%0d locked=%0d", err_count, locked);

        // line stuck low: four timeouts unlock
        mod_in = 0;
        repeat (40) tick();
        check_eq("err_stuck", err_count, 5);
        check_eq("unlock_stuck", locked, 0);
        $display("[TB] stuck phase: err=%0d locked=%0d", err_count, locked);

        // relock, then clear coincident with a bad symbol, then disable
        send_n(1, 20);
        check_eq("relock_err_hold", err_count, 5);
        check_eq("relock", locked, 1);
        clr_err = 1;
        send_sym(2, SYM);
        send_sym(1, SYM);
        clr_err = 0;
        check_eq("clr_err", err_count, 0);
        check_eq("lock_after_clr", locked, 1);
        enable = 0;
        tick();
        check_eq("disable_unlock", locked, 0);
        repeat (8) tick();
        enable = 1;
        $display("[TB] clear/disable phase: err=%0d locked=%0d", err_count, locked);

        // async reset mid-symbol
        mod_in = 0;
        repeat (4) tick();
        send_n(1, 20);
        check_eq("lock_pre_reset", locked, 1);
        mod_in = 1; tick();
        mod_in = 0; tick();
        reset_n = 0;
        #1;
        check_eq("reset_async", {27'd0, dut_outs()}, 0);
        model_reset();
        repeat (2) tick();
        reset_n = 1;
        repeat (3) tick();
        send_n(1, 16);
        check_eq("relock_early", locked, 0);
        send_n(1, 1);
        check_eq("relock_17", locked, 1);
        $display("[TB] reset phase: locked=%0d", locked);

        // random symbol stream
        for (int n = 0; n < 400; n++) begin
            int r;
            int hi;
            int len;
            r   = $urandom_range(0, 99);
            len = SYM;
            hi  = ($urandom_range(0, 1) == 1) ? 3 : 1;
            if (r < 3) hi = 2;
            else if (r < 5) len = $urandom_range(3, 5);
            else if (r < 6) hi = 0;
            else if (r < 7) hi = 4;
            enable  = ($urandom_range(0, 199) != 0);
            clr_err = ($urandom_range(0, 39) == 0);
            send_sym(hi, len);
        end
        enable = 1; clr_err = 0;
        $display("[TB] random phase done: err=%0d locked=%0d", err_count, locked);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
